mnist_image_reader: RTL

Streams the 28×28 drawn image out of `image_memory` to the network input layer. On `start` it walks every address 0..783 in raster order and issues one read per cycle through the memory read port. It absorbs the memory's one-cycle read latency and downstream backpressure with a 2-entry buffer. It emits each pixel as a normalised signed word on a valid/ready stream. It is the read-side counterpart of the drawing grid, which owns the write port of the same memory.

---
 rtl/mnist_image_reader_pkg.sv | 21 ++
 rtl/mnist_image_reader_if.sv | 37 +++
 rtl/mnist_image_reader_skid_fifo.sv | 71 +++++++
 rtl/mnist_image_reader.sv | 141 ++++++++++++++
 4 files changed

// File: rtl/mnist_image_reader_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mnist_pkg
//  Description : Shared constants and scan-state encoding for the image reader.
//  Revision    : 1.0 - initial release
// ============================================================================
package mnist_pkg;

    localparam int GRID_SIZE  = 28;
    localparam int NUM_PIXELS = GRID_SIZE * GRID_SIZE;
    localparam int PIX_ADDR_W = 10;
    localparam int DATA_WIDTH = 32;

    typedef enum logic [2:0] {
        IDLE  = 3'b001,
        SCAN  = 3'b010,
        DRAIN = 3'b100
    } state_e;

endpackage
`default_nettype wire

// File: rtl/mnist_image_reader_if.sv
`default_nettype none
// ============================================================================
//  Module      : mnist_image_reader_if
//  Description : Valid/ready pixel stream towards the network input layer.
//  Revision    : 1.0 - initial release
// ============================================================================
interface mnist_image_reader_if
    import mnist_pkg::*;
#(
    parameter int DATA_WIDTH = mnist_pkg::DATA_WIDTH,
    parameter int IDX_W      = mnist_pkg::PIX_ADDR_W
);

    logic                         out_valid;
    logic                         out_ready;
    logic signed [DATA_WIDTH-1:0] out_data;
    logic [IDX_W-1:0]             out_index;
    logic                         out_last;

    modport master (
        output out_valid,
        output out_data,
        output out_index,
        output out_last,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  out_data,
        input  out_index,
        input  out_last,
        output out_ready
    );

endinterface
`default_nettype wire

// File: rtl/mnist_image_reader_skid_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : mnist_skid_fifo
//  Description : 2-entry FIFO with registered head word and occupancy.
//  Revision    : 1.0 - initial release
// ============================================================================
module mnist_skid_fifo
    import mnist_pkg::*;
#(
    parameter int WIDTH = 43
) (
    input  wire logic             clk,
    input  wire logic             rst,
    input  wire logic             flush_i,
    input  wire logic             push_i,
    input  wire logic             pop_i,
    input  wire logic [WIDTH-1:0] din_i,
    output logic [WIDTH-1:0]      dout_o,
    output logic                  valid_o,
    output logic [1:0]            occ_o
);

    logic [WIDTH-1:0] head_q;
    logic [WIDTH-1:0] tail_q;
    logic [1:0]       occ_q;
    logic             do_pop;

    assign do_pop  = pop_i && (occ_q != 2'd0);
    assign dout_o  = head_q;
    assign valid_o = (occ_q != 2'd0);
    assign occ_o   = occ_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_q <= '0;
            tail_q <= '0;
            occ_q  <= 2'd0;
        end else if (flush_i) begin
            occ_q <= 2'd0;
        end else begin
            case ({push_i, do_pop})
                2'b10: begin
                    if (occ_q == 2'd0) begin
                        head_q <= din_i;
                        occ_q  <= 2'd1;
                    end else if (occ_q == 2'd1) begin
                        tail_q <= din_i;
                        occ_q  <= 2'd2;
                    end
                end
                2'b01: begin
                    head_q <= tail_q;
                    occ_q  <= occ_q - 2'd1;
                end
                2'b11: begin
                    // Simultaneous push/pop keeps occupancy; the new word lands behind any survivor
                    if (occ_q == 2'd1) begin
                        head_q <= din_i;
                    end else begin
                        head_q <= tail_q;
                        tail_q <= din_i;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/mnist_image_reader.sv
`default_nettype none
// ============================================================================
//  Module      : mnist_image_reader
//  Description : Raster-scans image_memory and streams normalised pixels out.
//  Revision    : 1.0 - initial release
// ============================================================================
module mnist_image_reader
    import mnist_pkg::*;
#(
    parameter int                           GRID_SIZE  = mnist_pkg::GRID_SIZE,
    parameter int                           DATA_WIDTH = mnist_pkg::DATA_WIDTH,
    parameter logic signed [DATA_WIDTH-1:0] ON_VALUE   = 32'sh0001_0000
) (
    input  wire logic                         CLOCK_50,
    input  wire logic                         reset,
    input  wire logic                         start,
    input  wire logic                         abort,
    output logic [15:0]                       read_addr,
    input  wire logic signed [DATA_WIDTH-1:0] mem_data,
    mnist_image_reader_if.master              strm,
    output logic                              busy,
    output logic                              done,
    output logic [PIX_ADDR_W-1:0]             pixel_count
);

    localparam int                    FIFO_W   = DATA_WIDTH + PIX_ADDR_W + 1;
    localparam logic [PIX_ADDR_W-1:0] LAST_IDX = PIX_ADDR_W'(GRID_SIZE * GRID_SIZE - 1);
    localparam logic [PIX_ADDR_W-1:0] PIX_MAX  = PIX_ADDR_W'(GRID_SIZE * GRID_SIZE);

    state_e                       state_q, state_d;
    logic [PIX_ADDR_W-1:0]        ptr_q, ptr_d;
    logic [PIX_ADDR_W-1:0]        infl_idx_q, infl_idx_d;
    logic [PIX_ADDR_W-1:0]        pix_cnt_q, pix_cnt_d;
    logic                         inflight_q, inflight_d;
    logic                         done_q, done_d;

    logic                         pop;
    logic                         credit;
    logic                         fifo_valid;
    logic [1:0]                   fifo_occ;
    logic [FIFO_W-1:0]            push_word;
    logic [FIFO_W-1:0]            head_word;
    logic signed [DATA_WIDTH-1:0] norm_data;

    assign pop       = fifo_valid & strm.out_ready;
    assign norm_data = (mem_data != '0) ? ON_VALUE : '0;
    assign push_word = {norm_data, infl_idx_q, (infl_idx_q == LAST_IDX)};

    // Words already buffered or arriving next cycle must leave room for this read
    assign credit = ({1'b0, fifo_occ} + {2'b00, inflight_q}) < (3'd2 + {2'b00, pop});

    mnist_skid_fifo #(
        .WIDTH (FIFO_W)
    ) u_fifo (
        .clk     (CLOCK_50),
        .rst     (reset),
        .flush_i (abort),
        .push_i  (inflight_q),
        .pop_i   (pop),
        .din_i   (push_word),
        .dout_o  (head_word),
        .valid_o (fifo_valid),
        .occ_o   (fifo_occ)
    );

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        infl_idx_d = infl_idx_q;
        pix_cnt_d  = pix_cnt_q;
        inflight_d = 1'b0;
        done_d     = 1'b0;

        if (pop && (strm.out_data != '0) && (pix_cnt_q != PIX_MAX)) begin
            pix_cnt_d = pix_cnt_q + 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d   = SCAN;
                    ptr_d     = '0;
                    pix_cnt_d = '0;
                end
            end
            SCAN: begin
                if (credit) begin
                    inflight_d = 1'b1;
                    infl_idx_d = ptr_q;
                    if (ptr_q == LAST_IDX) begin
                        state_d = DRAIN;
                    end else begin
                        ptr_d = ptr_q + 1'b1;
                    end
                end
            end
            DRAIN: begin
                if (pop && strm.out_last) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (abort) begin
            state_d    = IDLE;
            inflight_d = 1'b0;
            done_d     = 1'b0;
        end
    end

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            ptr_q      <= '0;
            infl_idx_q <= '0;
            pix_cnt_q  <= '0;
            inflight_q <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            infl_idx_q <= infl_idx_d;
            pix_cnt_q  <= pix_cnt_d;
            inflight_q <= inflight_d;
            done_q     <= done_d;
        end
    end

    assign read_addr      = 16'(ptr_q);
    assign busy           = (state_q != IDLE);
    assign done           = done_q;
    assign pixel_count    = pix_cnt_q;
    assign strm.out_valid = fifo_valid;
    assign {strm.out_data, strm.out_index, strm.out_last} = head_word;

endmodule
`default_nettype wire
